// File: rtl/fgyrus_pcm_rdr.sv
`default_nettype none
// ============================================================================
// Module   : fgyrus_pcm_rdr
// Purpose  : Sweeps the acortex->fgyrus PCM capture buffer on each bank-ready
//            pulse and streams the samples out as an interleaved L/R
//            valid/ready stream. Counts overruns (bank ready while busy).
// Revision : 1.0  initial release
// ============================================================================
module fgyrus_pcm_rdr #(
  parameter int NUM_SAMPLES  = 128,
  parameter int MEM_RD_DELAY = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int MEM_ADDR_W   = $clog2(NUM_SAMPLES) + 1,
  parameter int IDX_W        = $clog2(NUM_SAMPLES)
) (
  input  logic                  fgyrus_clk,
  input  logic                  fgyrus_rst_n,
  input  logic                  rdr_en,
  input  logic                  acortex2fgyrus_pcm_rdy,
  output logic [MEM_ADDR_W-1:0] fgyrus2acortex_addr,
  input  logic [31:0]           acortex2fgyrus_pcm_data,
  output logic                  pcm_valid,
  input  logic                  pcm_ready,
  output logic [31:0]           pcm_data,
  output logic                  pcm_chnl,
  output logic [IDX_W-1:0]      pcm_idx,
  output logic                  pcm_sof,
  output logic                  pcm_eof,
  output logic                  sweep_busy,
  output logic                  sweep_done,
  output logic [7:0]            ovrn_cnt,
  input  logic                  ovrn_clr
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 2;
  localparam int TAG_W  = IDX_W + 3;              // {eof, sof, chnl, idx}
  localparam int ENT_W  = TAG_W + 32;
  localparam int PIPE_N = MEM_RD_DELAY + 1;       // address stage + read latency
  localparam logic [MEM_ADDR_W-1:0] LAST_W = MEM_ADDR_W'(2 * NUM_SAMPLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [MEM_ADDR_W-1:0] w_q, w_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [PIPE_N-1:0]     pipe_vld_q, pipe_vld_d;
  logic [TAG_W-1:0]      pipe_tag_q [PIPE_N];
  logic [TAG_W-1:0]      pipe_tag_d [PIPE_N];
  logic [ENT_W-1:0]      fifo_mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]      fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [7:0]            ovrn_cnt_q, ovrn_cnt_d;

  logic [CNT_W-1:0]      inflight;
  logic                  start, issue, wr_en, pop, drain_done;
  logic [MEM_ADDR_W-1:0] w_issue;
  logic [IDX_W-1:0]      iss_idx;
  logic                  iss_chnl;
  logic [ENT_W-1:0]      head;

  // Count reads issued whose data has not yet landed in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_N; i++) begin
      inflight = inflight + CNT_W'(pipe_vld_q[i]);
    end
  end

  // Issue control: word 0 goes out in the same cycle the pulse is seen so the
  // address appears one cycle later; later words are credit-throttled.
  always_comb begin
    start      = (state_q == ST_IDLE) && acortex2fgyrus_pcm_rdy && rdr_en;
    issue      = start || ((state_q == ST_SWEEP) &&
                           ((fifo_cnt_q + inflight) < CNT_W'(FIFO_DEPTH)));
    w_issue    = start ? '0 : w_q;
    iss_chnl   = w_issue[0];
    iss_idx    = w_issue[MEM_ADDR_W-1:1];
    wr_en      = pipe_vld_q[PIPE_N-1];
    pop        = pcm_valid && pcm_ready;
    drain_done = (state_q == ST_DRAIN) && (inflight == '0) && (fifo_cnt_q == '0);
  end

  // Sweep FSM, word counter and read address.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE, ST_SWEEP: begin
        if (issue) begin
          addr_d  = iss_chnl ? (MEM_ADDR_W'(NUM_SAMPLES) + {1'b0, iss_idx})
                             : {1'b0, iss_idx};
          w_d     = w_issue + MEM_ADDR_W'(1);
          state_d = (w_issue == LAST_W) ? ST_DRAIN : ST_SWEEP;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tag shift register that tracks each read until its data returns.
  always_comb begin
    pipe_vld_d    = {pipe_vld_q[PIPE_N-2:0], issue};
    pipe_tag_d[0] = {(w_issue == LAST_W), (w_issue == '0), iss_chnl, iss_idx};
    for (int i = 1; i < PIPE_N; i++) begin
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  // Skid FIFO bookkeeping; credits guarantee it never overflows.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (wr_en) fifo_mem_d[wr_ptr_q] = {pipe_tag_q[PIPE_N-1], acortex2fgyrus_pcm_data};
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
  end

  // Saturating overrun counter; clear has priority over an increment.
  always_comb begin
    ovrn_cnt_d = ovrn_cnt_q;
    if (ovrn_clr) begin
      ovrn_cnt_d = '0;
    end else if (acortex2fgyrus_pcm_rdy && (state_q != ST_IDLE) && (ovrn_cnt_q != 8'hFF)) begin
      ovrn_cnt_d = ovrn_cnt_q + 8'd1;
    end
  end

  // Control state with asynchronous reset; a reset mid-sweep simply aborts.
  always_ff @(posedge fgyrus_clk or negedge fgyrus_rst_n) begin
    if (!fgyrus_rst_n) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      addr_q     <= '0;
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      ovrn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      addr_q     <= addr_d;
      pipe_vld_q <= pipe_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      ovrn_cnt_q <= ovrn_cnt_d;
    end
  end

  // Datapath storage; qualified by the valid bits so it needs no reset.
  always_ff @(posedge fgyrus_clk) begin
    pipe_tag_q <= pipe_tag_d;
    fifo_mem_q <= fifo_mem_d;
  end

  // FIFO head drives the stream; payload forced to zero when nothing is valid.
  always_comb begin
    head      = fifo_mem_q[rd_ptr_q];
    pcm_valid = (fifo_cnt_q != '0);
    pcm_data  = pcm_valid ? head[31:0] : '0;
    pcm_idx   = pcm_valid ? head[32 +: IDX_W] : '0;
    pcm_chnl  = pcm_valid && head[32 + IDX_W];
    pcm_sof   = pcm_valid && head[33 + IDX_W];
    pcm_eof   = pcm_valid && head[34 + IDX_W];
  end

  assign fgyrus2acortex_addr = addr_q;
  assign sweep_busy          = (state_q != ST_IDLE);
  assign sweep_done          = drain_done;
  assign ovrn_cnt            = ovrn_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fgyrus_pcm_rdr.sv
`default_nettype none
// ============================================================================
// Module   : tb_fgyrus_pcm_rdr
// Purpose  : Self-checking bench for fgyrus_pcm_rdr with a capture-memory
//            model and a word-sequence reference derived from the L/R layout.
// Revision : 1.0  initial release
// ============================================================================
module tb_fgyrus_pcm_rdr;

  localparam int N   = 128;
  localparam int MRD = 2;

  logic        fgyrus_clk = 1'b0;
  logic        fgyrus_rst_n;
  logic        rdr_en;
  logic        acortex2fgyrus_pcm_rdy;
  logic [7:0]  fgyrus2acortex_addr;
  logic [31:0] acortex2fgyrus_pcm_data;
  logic        pcm_valid;
  logic        pcm_ready;
  logic [31:0] pcm_data;
  logic        pcm_chnl;
  logic [6:0]  pcm_idx;
  logic        pcm_sof;
  logic        pcm_eof;
  logic        sweep_busy;
  logic        sweep_done;
  logic [7:0]  ovrn_cnt;
  logic        ovrn_clr;

  fgyrus_pcm_rdr #(.NUM_SAMPLES(N), .MEM_RD_DELAY(MRD), .FIFO_DEPTH(8)) dut (
    .fgyrus_clk              (fgyrus_clk),
    .fgyrus_rst_n            (fgyrus_rst_n),
    .rdr_en                  (rdr_en),
    .acortex2fgyrus_pcm_rdy  (acortex2fgyrus_pcm_rdy),
    .fgyrus2acortex_addr     (fgyrus2acortex_addr),
    .acortex2fgyrus_pcm_data (acortex2fgyrus_pcm_data),
    .pcm_valid               (pcm_valid),
    .pcm_ready               (pcm_ready),
    .pcm_data                (pcm_data),
    .pcm_chnl                (pcm_chnl),
    .pcm_idx                 (pcm_idx),
    .pcm_sof                 (pcm_sof),
    .pcm_eof                 (pcm_eof),
    .sweep_busy              (sweep_busy),
    .sweep_done              (sweep_done),
    .ovrn_cnt                (ovrn_cnt),
    .ovrn_clr                (ovrn_clr)
  );

  always #5 fgyrus_clk = ~fgyrus_clk;

  // Capture memory: data for an address appears MRD cycles later.
  logic [31:0] mem_arr [256];
  logic [7:0]  ap [MRD];
  always @(posedge fgyrus_clk) begin
    ap[0] <= fgyrus2acortex_addr;
    for (int i = 1; i < MRD; i++) ap[i] <= ap[i-1];
  end
  assign acortex2fgyrus_pcm_data = mem_arr[ap[MRD-1]];

  logic [41:0] pay;
  logic [60:0] all_outs;
  assign pay      = {pcm_data, pcm_chnl, pcm_idx, pcm_sof, pcm_eof};
  assign all_outs = {fgyrus2acortex_addr, pcm_valid, pay, sweep_busy, sweep_done, ovrn_cnt};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fill_mem(input bit rnd);
    for (int a = 0; a < 256; a++) mem_arr[a] = rnd ? $urandom : (32'h1000 + a);
  endtask

  // Reference: word k of a sweep is L[k/2] for even k, R[k/2] for odd k.
  function automatic logic [41:0] exp_word(input int k);
    int ch, ix, a;
    ch = k % 2;
    ix = k / 2;
    a  = (ch != 0) ? (N + ix) : ix;
    return {mem_arr[a], ch[0], ix[6:0], (k == 0), (k == 2 * N - 1)};
  endfunction

  // One full sweep from a rdy pulse, checking the stream against the model.
  task automatic do_sweep(input int rdy_pct, input int ov_word, input bit ov_drain,
                          input int en_off_word);
    int k, cyc, post, dones, first_valid;
    bit prev_stall, after_eof;
    logic [41:0] snap;
    k = 0; cyc = 0; post = 0; dones = 0; first_valid = -1;
    prev_stall = 1'b0; after_eof = 1'b0; snap = '0;
    @(negedge fgyrus_clk);
    pcm_ready = ($urandom_range(99, 0) < rdy_pct);
    acortex2fgyrus_pcm_rdy = 1'b1;
    while (cyc < 4000 && !(dones > 0 && post >= 5)) begin
      @(negedge fgyrus_clk);
      cyc++;
      acortex2fgyrus_pcm_rdy = 1'b0;
      if (dones > 0) post++;
      if (cyc == 1) begin
        chk("busy_start", sweep_busy, 1);
        chk("first_addr", fgyrus2acortex_addr, 0);
      end
      if (pcm_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall) chk("stall_hold", {pcm_valid, pay}, {1'b1, snap});
      if (after_eof) begin
        chk("done_after_eof", sweep_done, 1);
        after_eof = 1'b0;
      end
      if (sweep_done) begin
        dones++;
        if (ov_drain) acortex2fgyrus_pcm_rdy = 1'b1;
      end
      pcm_ready  = ($urandom_range(99, 0) < rdy_pct);
      prev_stall = pcm_valid && !pcm_ready;
      snap       = pay;
      if (pcm_valid && pcm_ready) begin
        if (k < 2 * N) chk("word", pay, exp_word(k));
        k++;
        if (k == ov_word) acortex2fgyrus_pcm_rdy = 1'b1;
        if (k == en_off_word) rdr_en = 1'b0;
        if (k == 2 * N) after_eof = 1'b1;
      end
    end
    if (cyc >= 4000) chk("sweep_timeout", cyc, 0);
    chk("first_valid_lat", first_valid, 4);
    chk("word_count", k, 2 * N);
    chk("done_count", dones, 1);
    chk("busy_end", sweep_busy, 0);
  endtask

  typedef struct {
    int rdy_pct;
    int ov_word;
    bit ov_drain;
    int en_off_word;
    bit rand_mem;
    int exp_ovrn;
  } scen_t;

  scen_t tbl [5];

  initial begin
    int n, guard;
    bit seen, pulsed;

    tbl[0] = '{rdy_pct: 100, ov_word: -1,  ov_drain: 1'b0, en_off_word: -1, rand_mem: 1'b0, exp_ovrn: 0};
    tbl[1] = '{rdy_pct: 70,  ov_word: -1,  ov_drain: 1'b0, en_off_word: -1, rand_mem: 1'b0, exp_ovrn: 0};
    tbl[2] = '{rdy_pct: 100, ov_word: 100, ov_drain: 1'b1, en_off_word: -1, rand_mem: 1'b0, exp_ovrn: 2};
    tbl[3] = '{rdy_pct: 100, ov_word: -1,  ov_drain: 1'b0, en_off_word: 10, rand_mem: 1'b0, exp_ovrn: 0};
    tbl[4] = '{rdy_pct: 50,  ov_word: 37,  ov_drain: 1'b0, en_off_word: -1, rand_mem: 1'b1, exp_ovrn: 1};

    fgyrus_rst_n = 1'b0; rdr_en = 1'b0; acortex2fgyrus_pcm_rdy = 1'b0;
    pcm_ready = 1'b0; ovrn_clr = 1'b0;
    fill_mem(1'b0);
    repeat (3) @(negedge fgyrus_clk);
    chk("reset_outputs", all_outs, 0);
    fgyrus_rst_n = 1'b1;
    @(negedge fgyrus_clk);
    chk("post_reset_outputs", all_outs, 0);

    // rdy pulse in IDLE with rdr_en low must be ignored entirely.
    acortex2fgyrus_pcm_rdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge fgyrus_clk);
      acortex2fgyrus_pcm_rdy = 1'b0;
      if (pcm_valid || sweep_busy) seen = 1'b1;
    end
    chk("en0_no_sweep", seen, 0);
    chk("en0_no_ovrn", ovrn_cnt, 0);

    for (int s = 0; s < 5; s++) begin
      @(negedge fgyrus_clk);
      ovrn_clr = 1'b1; rdr_en = 1'b1;
      @(negedge fgyrus_clk);
      ovrn_clr = 1'b0;
      fill_mem(tbl[s].rand_mem);
      do_sweep(tbl[s].rdy_pct, tbl[s].ov_word, tbl[s].ov_drain, tbl[s].en_off_word);
      chk("scen_ovrn", ovrn_cnt, 64'(tbl[s].exp_ovrn));
    end

    // Overrun saturation while the stream is stalled, then clear behaviour.
    fill_mem(1'b0);
    rdr_en = 1'b1; pcm_ready = 1'b0;
    @(negedge fgyrus_clk);
    ovrn_clr = 1'b1;
    @(negedge fgyrus_clk);
    ovrn_clr = 1'b0; acortex2fgyrus_pcm_rdy = 1'b1;
    @(negedge fgyrus_clk);
    acortex2fgyrus_pcm_rdy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge fgyrus_clk); acortex2fgyrus_pcm_rdy = 1'b1;
      @(negedge fgyrus_clk); acortex2fgyrus_pcm_rdy = 1'b0;
    end
    chk("ovrn_saturate", ovrn_cnt, 255);
    chk("stalled_head", {pcm_valid, pay}, {1'b1, exp_word(0)});
    ovrn_clr = 1'b1;
    @(negedge fgyrus_clk);
    ovrn_clr = 1'b0;
    chk("ovrn_clear", ovrn_cnt, 0);
    acortex2fgyrus_pcm_rdy = 1'b1;
    @(negedge fgyrus_clk);
    acortex2fgyrus_pcm_rdy = 1'b0;
    chk("ovrn_one", ovrn_cnt, 1);
    acortex2fgyrus_pcm_rdy = 1'b1; ovrn_clr = 1'b1;
    @(negedge fgyrus_clk);
    acortex2fgyrus_pcm_rdy = 1'b0; ovrn_clr = 1'b0;
    chk("ovrn_clr_wins", ovrn_cnt, 0);
    fgyrus_rst_n = 1'b0;
    repeat (2) @(negedge fgyrus_clk);
    fgyrus_rst_n = 1'b1;

    // Reset asserted around word 50 of a sweep aborts it without a done pulse.
    @(negedge fgyrus_clk);
    pcm_ready = 1'b1; acortex2fgyrus_pcm_rdy = 1'b1;
    n = 0; guard = 0; pulsed = 1'b0;
    while (n < 50 && guard < 1000) begin
      @(negedge fgyrus_clk);
      guard++;
      acortex2fgyrus_pcm_rdy = 1'b0;
      if (pcm_valid && pcm_ready) n++;
      if (n == 20 && !pulsed) begin
        acortex2fgyrus_pcm_rdy = 1'b1;
        pulsed = 1'b1;
      end
    end
    if (guard >= 1000) chk("rst_seq_timeout", guard, 0);
    chk("pre_reset_ovrn", ovrn_cnt, 1);
    fgyrus_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge fgyrus_clk);
      chk("midsweep_reset_outputs", all_outs, 0);
    end
    fgyrus_rst_n = 1'b1;
    rdr_en = 1'b1;
    do_sweep(100, -1, 1'b0, -1);
    chk("final_ovrn", ovrn_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
